// File: rtl/wt_dcache_mem_responder_if.sv
// Shared cache-memory types and the request/return/invalidation bundle
// between the write-through L1 data cache and its memory-side responder.
package wt_dcache_pkg;
  localparam int PLEN               = 56;
  localparam int DCACHE_LINE_WIDTH  = 128;
  localparam int DCACHE_SET_ASSOC   = 8;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TID_WIDTH   = 4;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ, DCACHE_STORE_REQ, DCACHE_ATOMIC_REQ, DCACHE_INT_REQ
  } dcache_out_t;

  typedef enum logic [2:0] {
    DCACHE_INV_REQ, DCACHE_LOAD_ACK, DCACHE_STORE_ACK, DCACHE_ATOMIC_ACK, DCACHE_INT_ACK
  } dcache_in_t;

  typedef enum logic [3:0] {
    AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
    AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
  } amo_t;

  typedef struct packed {
    dcache_out_t                         rtype;
    logic [2:0]                          size;
    logic [$clog2(DCACHE_SET_ASSOC)-1:0] way;
    logic [PLEN-1:0]                     paddr;
    logic                                nc;
    logic [63:0]                         data;
    logic [DCACHE_TID_WIDTH-1:0]         tid;
    amo_t                                amo_op;
  } dcache_req_t;

  typedef struct packed {
    logic                          vld;
    logic                          all;
    logic [DCACHE_INDEX_WIDTH-1:0] idx;
    logic [DCACHE_SET_ASSOC-1:0]   way;
  } dcache_inval_t;

  typedef struct packed {
    dcache_in_t                   rtype;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    dcache_inval_t                inv;
    logic [DCACHE_TID_WIDTH-1:0]  tid;
  } dcache_rtrn_t;
endpackage

interface wt_dcache_mem_responder_if;
  import wt_dcache_pkg::*;

  logic                        mem_data_req_i;
  dcache_req_t                 mem_data_i;
  logic                        mem_data_ack_o;
  logic                        mem_rtrn_vld_o;
  dcache_rtrn_t                mem_rtrn_o;
  logic                        inv_vld_i;
  logic                        inv_all_i;
  logic [PLEN-1:0]             inv_paddr_i;
  logic [DCACHE_SET_ASSOC-1:0] inv_way_i;
  logic                        inv_ack_o;

  modport master (
    output mem_data_req_i, mem_data_i, inv_vld_i, inv_all_i, inv_paddr_i, inv_way_i,
    input  mem_data_ack_o, mem_rtrn_vld_o, mem_rtrn_o, inv_ack_o
  );

  modport slave (
    input  mem_data_req_i, mem_data_i, inv_vld_i, inv_all_i, inv_paddr_i, inv_way_i,
    output mem_data_ack_o, mem_rtrn_vld_o, mem_rtrn_o, inv_ack_o
  );
endinterface

// File: rtl/wt_dcache_mem_responder.sv
// Fixed-latency memory responder for the write-through L1 data cache: one
// outstanding request served from a flop-based 64-bit-word store, plus injected invalidations.
module wt_dcache_mem_responder
  import wt_dcache_pkg::*;
#(
  parameter int unsigned Latency   = 2,
  parameter int unsigned MemWords  = 256,
  parameter int unsigned RdAmoTxId = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wt_dcache_mem_responder_if.slave   bus,
  output logic                       busy_o
);

  localparam int AW = $clog2(MemWords);
  localparam int LW = DCACHE_LINE_WIDTH / 64;
  localparam int CW = $clog2(Latency + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  dcache_req_t     req_q;
  logic [63:0]     mem_q [MemWords];

  logic [AW-1:0]   word_idx, line_base;
  logic [63:0]     old_word, wdata;
  logic [7:0]      mask;
  logic            ack, resp_fire, inv_fire, mem_we;

  function automatic logic [7:0] byte_mask(logic [2:0] size, logic [2:0] off);
    logic [7:0] m;
    case (size[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] merge_bytes(logic [63:0] old, logic [63:0] upd, logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[8*b +: 8] = upd[8*b +: 8];
    end
    return r;
  endfunction

  // In 32-bit mode each half is added on its own so no carry crosses lanes;
  // the byte mask later keeps only the addressed half.
  function automatic logic [63:0] amo_result(amo_t op, logic word_mode,
                                             logic [63:0] old, logic [63:0] opnd);
    logic [63:0] r;
    case (op)
      AMO_SWAP: r = opnd;
      AMO_ADD:  r = word_mode ? {old[63:32] + opnd[63:32], old[31:0] + opnd[31:0]}
                              : old + opnd;
      AMO_AND:  r = old & opnd;
      AMO_OR:   r = old | opnd;
      AMO_XOR:  r = old ^ opnd;
      default:  r = old;
    endcase
    return r;
  endfunction

  function automatic logic amo_writes(amo_t op);
    return op inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bus.mem_data_ack_o) req_q <= bus.mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[word_idx] <= wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_data_req_i) begin
          ack = 1'b1;
          if (Latency == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CW'(int'(Latency) - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign word_idx  = req_q.paddr[AW+2:3];
  assign line_base = word_idx & ~AW'(LW - 1);
  assign old_word  = mem_q[word_idx];
  assign mask      = byte_mask(req_q.size, req_q.paddr[2:0]);
  assign resp_fire = (state_q == RESP) && !rst_i;
  assign inv_fire  = bus.inv_vld_i && (state_q != RESP) && !rst_i;

  assign bus.mem_data_ack_o = ack && !rst_i;
  assign busy_o             = (state_q != IDLE) && !rst_i;

  // A due response owns the return channel; invalidations only fill idle slots.
  always_comb begin
    bus.mem_rtrn_o     = '0;
    bus.mem_rtrn_vld_o = 1'b0;
    bus.inv_ack_o      = 1'b0;
    mem_we             = 1'b0;
    wdata              = old_word;
    if (resp_fire) begin
      bus.mem_rtrn_vld_o = 1'b1;
      bus.mem_rtrn_o.tid = req_q.tid;
      case (req_q.rtype)
        DCACHE_LOAD_REQ: begin
          bus.mem_rtrn_o.rtype = DCACHE_LOAD_ACK;
          for (int i = 0; i < LW; i++) begin
            bus.mem_rtrn_o.data[64*i +: 64] = req_q.nc ? old_word
                                                       : mem_q[line_base + AW'(i)];
          end
        end
        DCACHE_STORE_REQ: begin
          bus.mem_rtrn_o.rtype = DCACHE_STORE_ACK;
          mem_we               = 1'b1;
          wdata                = merge_bytes(old_word, req_q.data, mask);
        end
        DCACHE_ATOMIC_REQ: begin
          bus.mem_rtrn_o.rtype      = DCACHE_ATOMIC_ACK;
          bus.mem_rtrn_o.data[63:0] = old_word;
          if (req_q.size[1] && amo_writes(req_q.amo_op)) begin
            mem_we = 1'b1;
            wdata  = merge_bytes(old_word,
                                 amo_result(req_q.amo_op, !req_q.size[0], old_word, req_q.data),
                                 mask);
          end
        end
        default: bus.mem_rtrn_o.rtype = DCACHE_INT_ACK;
      endcase
    end else if (inv_fire) begin
      bus.mem_rtrn_vld_o     = 1'b1;
      bus.inv_ack_o          = 1'b1;
      bus.mem_rtrn_o.rtype   = DCACHE_INV_REQ;
      bus.mem_rtrn_o.inv.vld = 1'b1;
      bus.mem_rtrn_o.inv.all = bus.inv_all_i;
      bus.mem_rtrn_o.inv.idx = bus.inv_paddr_i[DCACHE_INDEX_WIDTH-1:0];
      bus.mem_rtrn_o.inv.way = bus.inv_way_i;
    end
  end

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Scoreboard bench for wt_dcache_mem_responder: a word-array reference model
// predicts every return beat; a negedge monitor pops and compares them.
module tb_wt_dcache_mem_responder;
  import wt_dcache_pkg::*;

  localparam int LAT  = 2;
  localparam int MW   = 256;
  localparam int LW   = DCACHE_LINE_WIDTH / 64;
  localparam int TIDW = DCACHE_TID_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  wt_dcache_mem_responder_if bus();

  wt_dcache_mem_responder #(.Latency(LAT), .MemWords(MW), .RdAmoTxId(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .busy_o(busy)
  );

  typedef struct {
    logic [2:0]                    rtype;
    logic [DCACHE_LINE_WIDTH-1:0]  data;
    logic [TIDW-1:0]               tid;
    logic                          all;
    logic [DCACHE_INDEX_WIDTH-1:0] idx;
    logic [DCACHE_SET_ASSOC-1:0]   way;
    int                            cyc;
  } exp_t;

  exp_t        resp_q[$];
  exp_t        inv_q[$];
  exp_t        mon_e;
  logic [63:0] mdl [MW];
  int          cyc = 0;
  int          last_ack = -100;
  int          nvec = 0;
  int          nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] alu(amo_t op, logic [63:0] a, logic [63:0] b);
    case (op)
      AMO_SWAP: return b;
      AMO_ADD:  return a + b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_XOR:  return a ^ b;
      default:  return a;
    endcase
  endfunction

  // Reference behaviour: computes the beat the request must produce and applies its side effect.
  function automatic exp_t model(dcache_out_t rt, logic [2:0] sz, logic [PLEN-1:0] pa,
                                 logic nc, logic [63:0] d, logic [TIDW-1:0] tid, amo_t op, int c);
    exp_t        e;
    int          w, off, n, h;
    logic [63:0] old, r;
    bit          wr;
    w   = int'((pa >> 3) % MW);
    off = int'(pa[2:0]);
    n   = 1 << sz;
    old = mdl[w];
    e.data = '0; e.tid = tid; e.cyc = c + LAT; e.all = 0; e.idx = '0; e.way = '0;
    wr  = op inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR};
    case (rt)
      DCACHE_LOAD_REQ: begin
        e.rtype = DCACHE_LOAD_ACK;
        for (int i = 0; i < LW; i++) e.data[64*i +: 64] = nc ? old : mdl[(w / LW) * LW + i];
      end
      DCACHE_STORE_REQ: begin
        e.rtype = DCACHE_STORE_ACK;
        for (int b = off; b < off + n && b < 8; b++) mdl[w][8*b +: 8] = d[8*b +: 8];
      end
      DCACHE_ATOMIC_REQ: begin
        e.rtype = DCACHE_ATOMIC_ACK;
        e.data[63:0] = old;
        if (sz == 3'd2 && wr) begin
          h = off / 4;
          r = alu(op, {32'b0, old[32*h +: 32]}, {32'b0, d[32*h +: 32]});
          mdl[w][32*h +: 32] = r[31:0];
        end else if (sz == 3'd3 && wr) begin
          mdl[w] = alu(op, old, d);
        end
      end
      default: e.rtype = DCACHE_INT_ACK;
    endcase
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic do_req(input dcache_out_t rt, input logic [2:0] sz, input logic [PLEN-1:0] pa,
                        input logic nc, input logic [63:0] d, input logic [TIDW-1:0] tid,
                        input amo_t op, input bit model_it, output int ack_c);
    bit got = 0;
    bus.mem_data_i.rtype  = rt;
    bus.mem_data_i.size   = sz;
    bus.mem_data_i.way    = '0;
    bus.mem_data_i.paddr  = pa;
    bus.mem_data_i.nc     = nc;
    bus.mem_data_i.data   = d;
    bus.mem_data_i.tid    = tid;
    bus.mem_data_i.amo_op = op;
    bus.mem_data_req_i    = 1'b1;
    ack_c = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.mem_data_ack_o) begin got = 1; break; end
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL req_ack_timeout: got no ack expected ack within 50 cycles (cycle %0d)", cyc);
    end else begin
      ack_c    = cyc;
      last_ack = cyc;
      if (model_it) resp_q.push_back(model(rt, sz, pa, nc, d, tid, op, cyc));
    end
    @(posedge clk); #1;
    bus.mem_data_req_i = 1'b0;
  endtask

  task automatic do_inv(input logic all, input logic [PLEN-1:0] pa, input logic [DCACHE_SET_ASSOC-1:0] way);
    exp_t e;
    bit   due = 0;
    bit   got = 0;
    foreach (resp_q[i]) if (resp_q[i].cyc == cyc) due = 1;
    e.rtype = DCACHE_INV_REQ; e.data = '0; e.tid = '0; e.all = all;
    e.idx = pa[DCACHE_INDEX_WIDTH-1:0]; e.way = way; e.cyc = due ? cyc + 1 : cyc;
    inv_q.push_back(e);
    bus.inv_all_i   = all;
    bus.inv_paddr_i = pa;
    bus.inv_way_i   = way;
    bus.inv_vld_i   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.inv_ack_o) begin got = 1; break; end
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL inv_ack_timeout: got no inv_ack expected one within 20 cycles (cycle %0d)", cyc);
    end
    @(posedge clk); #1;
    bus.inv_vld_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_data_req_i)
        chk("ack_when_idle", bus.mem_data_ack_o, !(cyc > last_ack && cyc <= last_ack + LAT));
      chk("busy", busy, (cyc > last_ack && cyc <= last_ack + LAT));
      if (bus.mem_rtrn_vld_o) begin
        if (bus.mem_rtrn_o.rtype == DCACHE_INV_REQ) begin
          if (inv_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_inv: got INV_REQ beat expected none (cycle %0d)", cyc);
          end else begin
            mon_e = inv_q.pop_front();
            chk("inv_cycle", cyc, mon_e.cyc);
            chk("inv_ack", bus.inv_ack_o, 1);
            chk("inv_vld", bus.mem_rtrn_o.inv.vld, 1);
            chk("inv_all", bus.mem_rtrn_o.inv.all, mon_e.all);
            chk("inv_idx", bus.mem_rtrn_o.inv.idx, mon_e.idx);
            chk("inv_way", bus.mem_rtrn_o.inv.way, mon_e.way);
            chk("inv_tid", bus.mem_rtrn_o.tid, 0);
          end
        end else if (resp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_resp: got rtype %0d beat expected none (cycle %0d)",
                   bus.mem_rtrn_o.rtype, cyc);
        end else begin
          mon_e = resp_q.pop_front();
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("resp_rtype", bus.mem_rtrn_o.rtype, mon_e.rtype);
          chk("resp_data", bus.mem_rtrn_o.data, mon_e.data);
          chk("resp_tid", bus.mem_rtrn_o.tid, mon_e.tid);
          chk("resp_inv_vld", bus.mem_rtrn_o.inv.vld, 0);
          chk("resp_inv_ack", bus.inv_ack_o, 0);
        end
      end else begin
        chk("inv_ack_without_beat", bus.inv_ack_o, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int ac, ac2;
    dcache_out_t rt;
    logic [2:0] sz;
    logic [PLEN-1:0] pa;
    bus.mem_data_i  = '0;
    bus.inv_all_i   = 1'b0;
    bus.inv_paddr_i = '0;
    bus.inv_way_i   = '0;

    // Reset with a request and an invalidation both pending: nothing may answer.
    bus.mem_data_req_i = 1'b1;
    bus.inv_vld_i      = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", bus.mem_data_ack_o, 0);
      chk("rst_rtrn_vld", bus.mem_rtrn_vld_o, 0);
      chk("rst_inv_ack", bus.inv_ack_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rtrn_data", bus.mem_rtrn_o.data, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_data_req_i = 1'b0; bus.inv_vld_i = 1'b0; last_ack = -100;

    for (int w = 0; w < MW; w++)
      do_req(DCACHE_STORE_REQ, 3'd3, PLEN'(w * 8), 0, {$urandom, $urandom},
             TIDW'($urandom), AMO_NONE, 1, ac);

    do_req(DCACHE_STORE_REQ, 3'd3, 'h40, 0, 64'h1122334455667788, 3, AMO_NONE, 1, ac);
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h48, 0, 64'h0, 4, AMO_NONE, 1, ac);
    do_req(DCACHE_STORE_REQ, 3'd0, 'h45, 0, 64'hAB << 40, 5, AMO_NONE, 1, ac);
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h40, 1, 64'h0, 6, AMO_NONE, 1, ac);
    do_req(DCACHE_ATOMIC_REQ, 3'd2, 'h40, 0, 64'h1, 7, AMO_ADD, 1, ac);
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h40, 0, 64'h0, 8, AMO_NONE, 1, ac);
    do_req(DCACHE_ATOMIC_REQ, 3'd2, 'h44, 0, 64'hFFFF_FFFF_0000_0000, 9, AMO_ADD, 1, ac);
    do_req(DCACHE_INT_REQ, 3'd0, 'h0, 0, 64'h0, 10, AMO_NONE, 1, ac);

    // Invalidation raised exactly while the load is in RESP.
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h40, 0, 64'h0, 11, AMO_NONE, 1, ac);
    repeat (LAT - 1) @(posedge clk);
    #1;
    do_inv(0, PLEN'('h1_2345), 8'h20);

    // Request and invalidation arriving together in IDLE.
    fork
      do_req(DCACHE_LOAD_REQ, 3'd3, 'h80, 1, 64'h0, 12, AMO_NONE, 1, ac2);
      do_inv(1, PLEN'('hABC), 8'h01);
    join

    do_req(DCACHE_STORE_REQ, 3'd3, PLEN'(MW * 8 + 'h10), 0, 64'hCAFE_F00D_1234_5678, 13,
           AMO_NONE, 1, ac);
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h10, 1, 64'h0, 14, AMO_NONE, 1, ac);

    // Reset while the store waits: it must vanish without a beat or a write.
    do_req(DCACHE_STORE_REQ, 3'd3, 'h18, 0, 64'hDEAD_BEEF_DEAD_BEEF, 15, AMO_NONE, 0, ac);
    rst = 1'b1; last_ack = -100;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_req(DCACHE_LOAD_REQ, 3'd3, 'h18, 1, 64'h0, 1, AMO_NONE, 1, ac);

    for (int it = 0; it < 250; it++) begin
      rt = dcache_out_t'($urandom_range(0, 3));
      sz = (rt == DCACHE_ATOMIC_REQ) ? 3'($urandom_range(2, 3)) :
           (rt == DCACHE_INT_REQ)    ? 3'd0 : 3'($urandom_range(0, 3));
      pa = PLEN'($urandom_range(0, 2 * MW - 1)) << 3;
      pa[2:0] = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
      pa = pa | (PLEN'($urandom_range(0, 3)) << 24);
      do_req(rt, sz, pa, 1'($urandom), {$urandom, $urandom}, TIDW'($urandom),
             amo_t'($urandom_range(0, 13)), 1, ac);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, LAT - 1)) @(posedge clk);
        #1;
        do_inv(1'($urandom), {$urandom, $urandom}, DCACHE_SET_ASSOC'(1 << $urandom_range(0, 7)));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("inv_queue_drained", inv_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wt_dcache_mem_responder.md
# wt_dcache_mem_responder

Memory-side responder for the write-through L1 data cache's memory interface. It accepts `dcache_req_t` requests (loads, stores, atomics, interrupts) through the cache's req/ack handshake and answers with `dcache_rtrn_t` beats on the return channel after a fixed latency. It also lets the bench or system inject cache invalidations. It is backed by a small flop-based 64-bit-word memory and serves as the bench/FPGA-side counterpart of the cache's miss unit.

## Interface
Parameters:
- `Latency`, 2: cycles from the request ack to its return beat; legal values are ≥1.
- `MemWords`, 256: depth of the 64-bit backing store; must be a power of two.
- `RdAmoTxId`, 1: informational only; the responder echoes `tid` from each request.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mem_data_req_i`  in  1  request valid; held high until acked.
- `mem_data_i`  in  `dcache_req_t`  request fields: `rtype`, `size`, `way`, `paddr`, `nc`, `data`, `tid`, `amo_op`.
- `mem_data_ack_o`  out  1  request accepted this cycle.
- `mem_rtrn_vld_o`  out  1  return beat valid (single cycle, no backpressure).
- `mem_rtrn_o`  out  `dcache_rtrn_t`  return fields: `rtype`, `data` (DCACHE_LINE_WIDTH), `inv`, `tid`.
- `inv_vld_i`  in  1  invalidation request; held high until acked.
- `inv_all_i`  in  1  invalidate the whole cache.
- `inv_paddr_i`  in  riscv::PLEN  address whose index is invalidated.
- `inv_way_i`  in  DCACHE_SET_ASSOC  one-hot way to invalidate.
- `inv_ack_o`  out  1  invalidation sent this cycle.
- `busy_o`  out  1  a request is outstanding (state ≠ IDLE).

## Operation
- The FSM has three states: IDLE, WAIT, RESP. Only one request is outstanding at a time.
- IDLE: `mem_data_ack_o = mem_data_req_i` (combinational). On ack, capture the request. If `Latency==1`, go to RESP; otherwise load the counter with `Latency-2` and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
- RESP: assert `mem_rtrn_vld_o` and perform the memory access, then go to IDLE. The next ack can occur in the following cycle.
- Word index = `paddr[log2(MemWords)+2:3]`. Upper bits are ignored, so addresses wrap modulo MemWords.
- Byte mask comes from `size` (0/1/2/3 → 1/2/4/8 bytes) and `paddr[2:0]`. Store/AMO data is lane-aligned: byte k is at `data[8k+:8]`.
- LOAD, nc=0: return `LOAD_ACK` with the line-aligned line. That line is the DCACHE_LINE_WIDTH/64 consecutive words, lowest word in the low bits.
- LOAD, nc=1: return `LOAD_ACK` with the addressed 64-bit word replicated across the line.
- STORE: byte-masked write at the end of the RESP cycle; return `STORE_ACK`. `data` on the return is 0.
- ATOMIC, size 2 or 3, operating on the masked lanes:
  - `AMO_SWAP` writes new = operand.
  - `AMO_ADD` writes new = old + operand, computed modulo the operand width (32 or 64 bits), with no carry into the other half.
  - `AMO_AND`, `AMO_OR` and `AMO_XOR` write the bitwise result.
  - Every other `amo_op` leaves memory unchanged.
  - All atomics return `ATOMIC_ACK` with the full old 64-bit word in `data[63:0]`; upper line bits are 0.
- INT request: no memory access; return `INT_ACK`.
- Every return echoes the captured `tid`, with `inv.vld=0`.
- Invalidation:
  - Sent when `inv_vld_i` is high and the FSM is not in RESP. The beat has `rtype=INV_REQ`, `inv.vld=1`, `inv.all=inv_all_i`, `inv.idx` taken from `inv_paddr_i`'s index bits, `inv.way=inv_way_i`, and `tid=0`.
  - `inv_ack_o` pulses in the same cycle as that beat.
  - A due response in RESP always wins; a pending invalidation waits and goes out the next cycle.
- Invalidation never touches the backing memory.

## Timing
- Reset values: FSM in IDLE, counter 0. All outputs are 0 in the reset cycle. `mem_data_ack_o` is forced to 0 while `rst_i` is high.
- Memory contents are not reset.
- Ack cycle t gives `mem_rtrn_vld_o` exactly at t+`Latency`.
- Back-to-back requests give one request every `Latency+1` cycles.
- A load issued the cycle after a store's RESP to the same word sees the stored data.
- At most one return beat per cycle. `mem_rtrn_vld_o` and `inv_ack_o` are asserted together only for an invalidation beat.
- Reset asserted mid-operation: the captured request is discarded, no return beat is produced, and a partial store is not written.
- `inv_vld_i` held while a request arrives in IDLE: both are served in the same cycle. The request is acked and the invalidation beat is sent, because the two do not conflict outside RESP.

## Test plan
All scenarios use DCACHE_LINE_WIDTH=128 and Latency=2.
- Reset: assert `rst_i` for 2 cycles → all outputs 0, `busy_o`=0; request held during reset gets no ack.
- Store then load: store size 3 to 0x40 with data 0x1122334455667788, tid 3. Expected: ack at t, STORE_ACK with tid 3 at t+2. Then load nc=0 to 0x48 → LOAD_ACK with `data[63:0]`=0x1122334455667788.
- Byte store: store size 0 to 0x45 with byte 0xAB placed in lane 5. Then nc=1 load of 0x40 → word 0x1122AB4455667788 appears in both 64-bit halves of the line.
- AMO_ADD: 32-bit add at 0x40 with operand 0x00000001 on low word 0x55667788. Expected: ATOMIC_ACK with old 0x1122AB4455667788; a subsequent load returns low word 0x55667789.
- Invalidation collision: `inv_vld_i` raised in the cycle the load is in RESP → LOAD_ACK that cycle, INV_REQ with `inv_ack_o` the next cycle, `inv.way` equal to `inv_way_i`.
- Wrap and reset: store to `MemWords*8 + 0x10`, then load 0x10 → same data. Reset asserted during WAIT → no return beat; the next request completes normally.
